pcm_fifo: RTL

Sample buffer directly downstream of the 1-bit symmetric FIR decimator. It captures each 16-bit PCM result the filter strobes out with Push and holds it in a DEPTH-entry FIFO. Samples are released to the consumer over a valid/ready handshake, so a stalled consumer never loses samples until the buffer is full. Overflow is flagged sticky, and a high-water indication lets the consumer drain in bursts.

---
 rtl/pcm_pkg.sv | 10 +
 rtl/pcm_fifo_if.sv | 31 +++
 rtl/pcm_fifo_mem.sv | 26 ++
 rtl/pcm_fifo.sv | 96 +++++++++
 4 files changed

// File: rtl/pcm_pkg.sv
// Shared PCM sample definitions for the FIR decimator and its output buffer.
package pcm_pkg;

  localparam int unsigned PCM_WIDTH      = 16;
  localparam int unsigned PCM_DEPTH      = 16;
  localparam int unsigned PCM_HIGH_WATER = 12;

  typedef logic signed [PCM_WIDTH-1:0] pcm_t;

endpackage

// File: rtl/pcm_fifo_if.sv
// Producer/consumer bundle of the PCM sample FIFO; slave is the FIFO side.
interface pcm_fifo_if import pcm_pkg::*; #(
  parameter int unsigned DEPTH = PCM_DEPTH,
  parameter int unsigned WIDTH = PCM_WIDTH
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             Push;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Dout;
  logic             Valid;
  logic             Ready;
  logic [CW-1:0]    Count;
  logic             Full;
  logic             Empty;
  logic             HighWater;
  logic             Overflow;
  logic             OvfClear;

  modport master (
    output Push, Din, Ready, OvfClear,
    input  Dout, Valid, Count, Full, Empty, HighWater, Overflow
  );

  modport slave (
    input  Push, Din, Ready, OvfClear,
    output Dout, Valid, Count, Full, Empty, HighWater, Overflow
  );

endinterface

// File: rtl/pcm_fifo_mem.sv
// Sample storage: one synchronous write port, one asynchronous read port.
module pcm_fifo_mem import pcm_pkg::*; #(
  parameter int unsigned DEPTH = PCM_DEPTH,
  parameter int unsigned WIDTH = PCM_WIDTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; the top gates Dout while empty.
  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pcm_fifo.sv
// PCM sample FIFO between the decimator and its consumer, with sticky overflow
// and a high-water flag; all outputs come from registered state.
module pcm_fifo import pcm_pkg::*; #(
  parameter int unsigned DEPTH      = PCM_DEPTH,
  parameter int unsigned WIDTH      = PCM_WIDTH,
  parameter int unsigned HIGH_WATER = PCM_HIGH_WATER
) (
  input  logic       Clock,
  input  logic       Reset,
  pcm_fifo_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] FullDiff = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] HwLevel  = CW'(HIGH_WATER);
  localparam logic [CW-1:0] PtrOne   = CW'(1);

  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, pop, push_ok, drop;
  logic [WIDTH-1:0] rd_data;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == FullDiff);

  // A pop frees the slot the write lands in, so push is accepted when full.
  assign pop     = ~empty & bus.Ready;
  assign push_ok = bus.Push & (~full | pop);
  assign drop    = bus.Push & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + PtrOne;
      2'b01:   count_d = count_q - PtrOne;
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.OvfClear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  pcm_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .Clock   (Clock),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (bus.Din),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rd_data)
  );

  assign bus.Dout      = empty ? '0 : rd_data;
  assign bus.Valid     = ~empty;
  assign bus.Empty     = empty;
  assign bus.Full      = full;
  assign bus.Count     = count_q;
  assign bus.HighWater = (count_q >= HwLevel);
  assign bus.Overflow  = overflow_q;

endmodule
